// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding,
// slice width and the index-width helper.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index: clog2(n), but never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle of the nibble-serial adder.
interface nibble_serial_adder_if
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;
    logic         ov;

    modport master (output start, a, b, ci, input busy, done, s, co, ov);
    modport slave  (input start, a, b, ci, output busy, done, s, co, ov);
endinterface

// File: rtl/nibble_serial_adder_rca4.sv
// Existing 4-bit ripple-carry adder, used as the per-nibble datapath.
module nibble_serial_adder_rca4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_ci,
    output logic [NIBBLE_W-1:0] o_s,
    output logic                o_co
);
    logic [NIBBLE_W:0] w_c;

    // Ripple the carry through four full adders.
    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_ci;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
        o_co = w_c[NIBBLE_W];
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that feeds one nibble per clock through a single 4-bit
// ripple-carry adder, LSB nibble first, keeping the carry in a register.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
)
(
    input  logic                 clk,
    input  logic                 reset,
    nibble_serial_adder_if.slave bus
);
    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = idx_width(NIBBLES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_work;
    logic [W-1:0]      r_s;
    logic              r_co;
    logic              r_ov;

    logic [W-1:0]          w_a_sh;
    logic [W-1:0]          w_b_sh;
    logic [NIBBLE_W-1:0]   w_nib_s;
    logic                  w_nib_co;
    logic [W-1:0]          w_work_nxt;
    logic                  w_last;
    logic                  w_ov;

    assign w_a_sh = r_a >> (NIBBLE_W * r_idx);
    assign w_b_sh = r_b >> (NIBBLE_W * r_idx);
    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

    nibble_serial_adder_rca4 u_rca4 (
        .i_a  (w_a_sh[NIBBLE_W-1:0]),
        .i_b  (w_b_sh[NIBBLE_W-1:0]),
        .i_ci (r_carry),
        .o_s  (w_nib_s),
        .o_co (w_nib_co)
    );

    // Work word with the current nibble's sum merged in at slot idx.
    always_comb begin
        w_work_nxt = r_work;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_work_nxt[NIBBLE_W*n +: NIBBLE_W] = w_nib_s;
            end
        end
        w_ov = (r_a[W-1] == r_b[W-1]) && (w_work_nxt[W-1] != r_a[W-1]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch, per-nibble accumulation and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_work  <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.ci;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    r_work  <= w_work_nxt;
                    r_carry <= w_nib_co;
                    r_idx   <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        r_s  <= w_work_nxt;
                        r_co <= w_nib_co;
                        r_ov <= w_ov;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.s  = r_s;
    assign bus.co = r_co;
    assign bus.ov = r_ov;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a 4-nibble and a 1-nibble instance, driven
// from vector tables plus hand-written corner sequences, results checked
// through per-instance scoreboards.
module tb_nibble_serial_adder;
    import nibble_serial_adder_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic clk;
    logic reset;

    int checks    = 0;
    int errors    = 0;
    int done4_cnt = 0;
    int done1_cnt = 0;
    logic done4_prev = 1'b0;
    logic done1_prev = 1'b0;

    exp_t sb4[$];
    exp_t sb1[$];
    exp_t e4;
    exp_t e1;

    vec_t tab4[11];
    vec_t tab1[5];

    nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
    nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard for the 4-nibble instance.
    always @(negedge clk) begin
        if (bus4.done) begin
            done4_cnt++;
            chk("done4_single_cycle", 32'(done4_prev), 32'd0);
            chk("sb4_pending", sb4.size(), 32'd1);
            if (sb4.size() != 0) begin
                e4 = sb4.pop_front();
                chk("s4", 32'(bus4.s), 32'(e4.s));
                chk("co4", 32'(bus4.co), 32'(e4.co));
                chk("ov4", 32'(bus4.ov), 32'(e4.ov));
            end
        end
        done4_prev = bus4.done;
    end

    // Scoreboard for the 1-nibble instance.
    always @(negedge clk) begin
        if (bus1.done) begin
            done1_cnt++;
            chk("done1_single_cycle", 32'(done1_prev), 32'd0);
            chk("sb1_pending", sb1.size(), 32'd1);
            if (sb1.size() != 0) begin
                e1 = sb1.pop_front();
                chk("s1", 32'(bus1.s), 32'(e1.s[3:0]));
                chk("co1", 32'(bus1.co), 32'(e1.co));
                chk("ov1", 32'(bus1.ov), 32'(e1.ov));
            end
        end
        done1_prev = bus1.done;
    end

    // Called at #1 after an edge with the 4-nibble instance in IDLE.
    task automatic run4(input vec_t v);
        int n;
        int nbusy;
        bus4.a     = v.a;
        bus4.b     = v.b;
        bus4.ci    = v.ci;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        sb4.push_back('{v.s, v.co, v.ov});
        bus4.start = 1'b0;
        n = 0;
        nbusy = 0;
        while (!bus4.done && n < 20) begin
            if (bus4.busy) nbusy++;
            @(posedge clk); #1;
            n++;
        end
        chk("latency4", n, 32'd4);
        chk("busy_cycles4", nbusy, 32'd4);
        @(posedge clk); #1;
    endtask

    task automatic run1(input vec_t v);
        int n;
        int nbusy;
        bus1.a     = v.a[3:0];
        bus1.b     = v.b[3:0];
        bus1.ci    = v.ci;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        sb1.push_back('{v.s, v.co, v.ov});
        bus1.start = 1'b0;
        n = 0;
        nbusy = 0;
        while (!bus1.done && n < 20) begin
            if (bus1.busy) nbusy++;
            @(posedge clk); #1;
            n++;
        end
        chk("latency1", n, 32'd1);
        chk("busy_cycles1", nbusy, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        logic [3:0] car_exp;

        //           a         b         ci    s         co    ov
        tab4[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        tab4[1]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tab4[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tab4[3]  = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        tab4[4]  = '{16'h0002, 16'h0004, 1'b0, 16'h0006, 1'b0, 1'b0};
        tab4[5]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        tab4[6]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        tab4[7]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tab4[8]  = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
        tab4[9]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tab4[10] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};

        tab1[0]  = '{16'h000F, 16'h0008, 1'b1, 16'h0008, 1'b1, 1'b0};
        tab1[1]  = '{16'h0007, 16'h0001, 1'b0, 16'h0008, 1'b0, 1'b1};
        tab1[2]  = '{16'h0008, 16'h0008, 1'b0, 16'h0000, 1'b1, 1'b1};
        tab1[3]  = '{16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tab1[4]  = '{16'h0005, 16'h0002, 1'b1, 16'h0008, 1'b0, 1'b1};

        reset      = 1'b1;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus4.ci    = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.ci    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_busy4", 32'(bus4.busy), 32'd0);
        chk("rst_done4", 32'(bus4.done), 32'd0);
        chk("rst_s4", 32'(bus4.s), 32'd0);
        chk("rst_co4", 32'(bus4.co), 32'd0);
        chk("rst_ov4", 32'(bus4.ov), 32'd0);
        chk("rst_state4", 32'(dut4.r_state), 32'(IDLE));
        chk("rst_s1", 32'(bus1.s), 32'd0);
        chk("rst_busy1", 32'(bus1.busy), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run4(tab4[i]);
        end

        // Carry register after every RUN edge for a full-length ripple.
        bus4.a     = 16'h0FFF;
        bus4.b     = 16'h0000;
        bus4.ci    = 1'b1;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        sb4.push_back('{16'h1000, 1'b0, 1'b0});
        bus4.start = 1'b0;
        chk("carry_e0", 32'(dut4.r_carry), 32'd1);
        car_exp = 4'b0111;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            chk("carry_run", 32'(dut4.r_carry), 32'(car_exp[k-1]));
        end
        chk("carry_seq_done", 32'(bus4.done), 32'd1);
        @(posedge clk); #1;

        // Reset in the second RUN cycle discards the operation.
        bus4.a     = 16'h1234;
        bus4.b     = 16'h4321;
        bus4.ci    = 1'b0;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(bus4.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", 32'(bus4.busy), 32'd0);
        chk("midrst_done", 32'(bus4.done), 32'd0);
        chk("midrst_s", 32'(bus4.s), 32'd0);
        chk("midrst_co", 32'(bus4.co), 32'd0);
        chk("midrst_ov", 32'(bus4.ov), 32'd0);
        chk("midrst_state", 32'(dut4.r_state), 32'(IDLE));
        chk("midrst_carry", 32'(dut4.r_carry), 32'd0);
        chk("midrst_idx", 32'(dut4.r_idx), 32'd0);
        run4(tab4[4]);

        // start held high; operands wiggled during RUN.
        d0 = done4_cnt;
        bus4.a     = 16'h1111;
        bus4.b     = 16'h2222;
        bus4.ci    = 1'b0;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        sb4.push_back('{16'h3333, 1'b0, 1'b0});
        n = 0;
        while (!bus4.done && n < 20) begin
            bus4.a  = 16'($urandom);
            bus4.b  = 16'($urandom);
            bus4.ci = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("hold_latency", n, 32'd4);
        bus4.a  = 16'h0F0F;
        bus4.b  = 16'h0101;
        bus4.ci = 1'b1;
        @(posedge clk); #1;
        chk("hold_done_ignored_busy", 32'(bus4.busy), 32'd0);
        chk("hold_done_ignored_state", 32'(dut4.r_state), 32'(IDLE));
        @(posedge clk); #1;
        chk("hold_accept_busy", 32'(bus4.busy), 32'd1);
        sb4.push_back('{16'h1011, 1'b0, 1'b0});
        bus4.start = 1'b0;
        n = 0;
        while (!bus4.done && n < 20) begin
            bus4.a = 16'($urandom);
            bus4.b = 16'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("hold_latency2", n, 32'd4);
        @(posedge clk); #1;
        chk("hold_done_count", done4_cnt - d0, 32'd2);

        for (int i = 0; i < 5; i++) begin
            run1(tab1[i]);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("sb4_drained", sb4.size(), 32'd0);
        chk("sb1_drained", sb1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
